// File: rtl/mdrp_pkg.sv
// Shared opcodes, lock-sequencer state encoding and register reset table for the MDRP PLL responder.
package mdrp_pkg;

    localparam logic [1:0] MDRP_OPC_NOP = 2'b00;
    localparam logic [1:0] MDRP_OPC_WR  = 2'b01;
    localparam logic [1:0] MDRP_OPC_RD  = 2'b10;
    localparam logic [1:0] MDRP_OPC_CLR = 2'b11;

    typedef enum logic [2:0] {
        HOLD   = 3'd0,
        CHECK  = 3'd1,
        ACQ    = 3'd2,
        LOCKED = 3'd3,
        FAIL   = 3'd4
    } lock_state_t;

    function automatic logic [7:0] mdrp_rst_val(input logic [7:0] addr);
        logic [7:0] val;
        case (addr)
            8'h0B:   val = 8'h00;
            8'h0C:   val = 8'h80;
            8'h11:   val = 8'h01;
            8'h12:   val = 8'h08;
            default: val = 8'h00;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/mdrp_lock_model.sv
// Emulated PLL lock sequencer: configuration check, acquisition delay, registered lock/config-error flags.
// Define MDRP_LOCK_GLITCH_EN to drop lock for 4 cycles, 16 cycles into the first lock after each release.
module mdrp_lock_model
    import mdrp_pkg::*;
#(
    parameter int LOCK_DLY = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pll_rst,
    input  logic cfg_write,
    input  logic field_ok,
    output logic lock,
    output logic cfg_err
);

    localparam logic [15:0] ACQ_LAST  = 16'(LOCK_DLY - 1);
    localparam logic [15:0] ACQ_ONE   = 16'd1;
    localparam logic [4:0]  GLT_START = 5'd16;
    localparam logic [4:0]  GLT_END   = 5'd19;
    localparam logic [4:0]  GLT_SAT   = 5'd20;

    lock_state_t state_r;
    logic [15:0] acqCnt_r;
    logic [4:0]  glitchCnt_r;
    logic        lock_r;
    logic        cfgErr_r;
    logic        glitchDip_s;

`ifdef MDRP_LOCK_GLITCH_EN
    // Lock drop window, measured in LOCKED cycles since the PLL left reset
    always_comb begin
        glitchDip_s = 1'b0;
        if (glitchCnt_r >= GLT_START && glitchCnt_r <= GLT_END) begin
            glitchDip_s = 1'b1;
        end else begin
            glitchDip_s = 1'b0;
        end
    end
`else
    // Lock stays steady once acquired
    always_comb begin
        glitchDip_s = 1'b0;
    end
`endif

    // Lock sequencer: PLL reset dominates, then config writes restart the check
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= HOLD;
            acqCnt_r    <= 16'd0;
            glitchCnt_r <= 5'd0;
            lock_r      <= 1'b0;
            cfgErr_r    <= 1'b0;
        end else if (pll_rst) begin
            state_r     <= HOLD;
            acqCnt_r    <= 16'd0;
            glitchCnt_r <= 5'd0;
            lock_r      <= 1'b0;
        end else if (cfg_write && (state_r != HOLD)) begin
            state_r  <= CHECK;
            acqCnt_r <= 16'd0;
            lock_r   <= 1'b0;
        end else begin
            case (state_r)
                HOLD: begin
                    state_r  <= CHECK;
                    acqCnt_r <= 16'd0;
                    lock_r   <= 1'b0;
                end
                CHECK: begin
                    acqCnt_r <= 16'd0;
                    lock_r   <= 1'b0;
                    if (field_ok) begin
                        state_r  <= ACQ;
                        cfgErr_r <= 1'b0;
                    end else begin
                        state_r  <= FAIL;
                        cfgErr_r <= 1'b1;
                    end
                end
                ACQ: begin
                    lock_r <= 1'b0;
                    if (acqCnt_r == ACQ_LAST) begin
                        state_r <= LOCKED;
                    end else begin
                        acqCnt_r <= acqCnt_r + ACQ_ONE;
                    end
                end
                LOCKED: begin
                    lock_r <= ~glitchDip_s;
                    if (glitchCnt_r < GLT_SAT) begin
                        glitchCnt_r <= glitchCnt_r + 5'd1;
                    end
                end
                FAIL: begin
                    lock_r <= 1'b0;
                end
                default: begin
                    state_r <= HOLD;
                    lock_r  <= 1'b0;
                end
            endcase
        end
    end

    assign lock    = lock_r;
    assign cfg_err = cfgErr_r;

endmodule

// File: rtl/mdrp_pll_responder.sv
// MDRP PLL responder: auto-increment pointer, byte register bank, registered read path, emulated lock.
// Optional MDRP_LOCK_GLITCH_EN adds a one-shot lock drop inside mdrp_lock_model.
module mdrp_pll_responder
    import mdrp_pkg::*;
#(
    parameter int          NUM_REGS  = 32,
    parameter int          LOCK_DLY  = 64,
    parameter logic [7:0]  LOCK_REG  = 8'h11,
    parameter logic [7:0]  LOCK_MASK = 8'h07,
    parameter int          LOCK_MIN  = 3,
    parameter int          LOCK_MAX  = 7,
    localparam int         AW        = $clog2(NUM_REGS)
) (
    input  logic          I_MD_CLK,
    input  logic          I_RST_N,
    input  logic          I_MD_INC,
    input  logic [1:0]    I_MD_OPC,
    input  logic [7:0]    I_MD_WR_DATA,
    output logic [7:0]    O_MD_RD_DATA,
    input  logic          I_PLL_RST,
    output logic          O_LOCK,
    output logic          O_CFG_ERR,
    output logic [AW-1:0] O_PTR
);

    localparam logic [AW-1:0] PTR_LAST  = AW'(NUM_REGS - 1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [7:0]    FIELD_MIN = 8'(LOCK_MIN);
    localparam logic [7:0]    FIELD_MAX = 8'(LOCK_MAX);

    logic [7:0]    regBank_r [NUM_REGS];
    logic [AW-1:0] ptr_r;
    logic [7:0]    rdData_r;
    logic          pllRstPrev_r;
    logic [7:0]    lockField_s;
    logic          fieldOk_s;
    logic          cfgWrite_s;
    logic          pllFall_s;

    // Lock-field decode and strobes derived from the current opcode and PLL reset
    always_comb begin
        lockField_s = regBank_r[LOCK_REG[AW-1:0]] & LOCK_MASK;
        cfgWrite_s  = (I_MD_OPC == MDRP_OPC_WR);
        pllFall_s   = pllRstPrev_r & ~I_PLL_RST;
        if ((lockField_s >= FIELD_MIN) && (lockField_s <= FIELD_MAX)) begin
            fieldOk_s = 1'b1;
        end else begin
            fieldOk_s = 1'b0;
        end
    end

    // Register bank, read data and pointer; prev-PLL-reset starts high so a release straight out of reset clears ptr
    always_ff @(posedge I_MD_CLK) begin
        if (!I_RST_N) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regBank_r[i] <= mdrp_rst_val(8'(i));
            end
            ptr_r        <= {AW{1'b0}};
            rdData_r     <= 8'h00;
            pllRstPrev_r <= 1'b1;
        end else begin
            pllRstPrev_r <= I_PLL_RST;
            case (I_MD_OPC)
                MDRP_OPC_WR: regBank_r[ptr_r] <= I_MD_WR_DATA;
                MDRP_OPC_RD: rdData_r         <= regBank_r[ptr_r];
                default:     rdData_r         <= rdData_r;
            endcase
            if ((I_MD_OPC == MDRP_OPC_CLR) || pllFall_s) begin
                ptr_r <= {AW{1'b0}};
            end else if (I_MD_INC) begin
                ptr_r <= (ptr_r == PTR_LAST) ? {AW{1'b0}} : (ptr_r + PTR_ONE);
            end else begin
                ptr_r <= ptr_r;
            end
        end
    end

    mdrp_lock_model #(
        .LOCK_DLY (LOCK_DLY)
    ) u_lock (
        .clk       (I_MD_CLK),
        .rst_n     (I_RST_N),
        .pll_rst   (I_PLL_RST),
        .cfg_write (cfgWrite_s),
        .field_ok  (fieldOk_s),
        .lock      (O_LOCK),
        .cfg_err   (O_CFG_ERR)
    );

    assign O_MD_RD_DATA = rdData_r;
    assign O_PTR        = ptr_r;

endmodule

// File: tb/tb_mdrp_pll_responder.sv
// Scoreboard bench for mdrp_pll_responder: directed scenarios plus randomized traffic against a timeline model.
module tb_mdrp_pll_responder;

    localparam int LOCK_DLY = 64;
`ifdef MDRP_LOCK_GLITCH_EN
    localparam bit GLITCH = 1'b1;
`else
    localparam bit GLITCH = 1'b0;
`endif

    localparam logic [1:0] NOP = 2'b00;
    localparam logic [1:0] WR  = 2'b01;
    localparam logic [1:0] RD  = 2'b10;
    localparam logic [1:0] CLR = 2'b11;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic       mdInc = 1'b0;
    logic [1:0] mdOpc = 2'b00;
    logic [7:0] wrData = 8'h00;
    logic [7:0] rdData;
    logic       pllRst = 1'b1;
    logic       lockOut;
    logic       cfgErr;
    logic [4:0] ptrOut;

    always #5 clk = ~clk;

    mdrp_pll_responder dut (
        .I_MD_CLK     (clk),
        .I_RST_N      (rstN),
        .I_MD_INC     (mdInc),
        .I_MD_OPC     (mdOpc),
        .I_MD_WR_DATA (wrData),
        .O_MD_RD_DATA (rdData),
        .I_PLL_RST    (pllRst),
        .O_LOCK       (lockOut),
        .O_CFG_ERR    (cfgErr),
        .O_PTR        (ptrOut)
    );

    typedef struct {
        logic [7:0] rd;
        logic       lock;
        logic       err;
        logic [4:0] ptr;
    } exp_t;

    exp_t expQ[$];
    int   nTests = 0;
    int   nFails = 0;

    // Reference state: register contents, pointer, and lock timeline bookkeeping
    logic [7:0] mRegs [32];
    int         mPtr = 0;
    logic [7:0] mRd = 8'h00;
    bit         mLock = 1'b0;
    bit         mErr = 1'b0;
    bit         mActive = 1'b0;
    int         mN = 0;
    int         mStart = -1000;
    bit         mOk = 1'b0;
    int         mLockedEdges = 0;

    function automatic logic [7:0] rstVal(input int a);
        if (a == 12) return 8'h80;
        if (a == 17) return 8'h01;
        if (a == 18) return 8'h08;
        return 8'h00;
    endfunction

    // One clock edge of the reference: PLL "active" means it was out of reset at that edge
    task automatic modelStep(input logic rn, input logic inc, input logic [1:0] opc,
                             input logic [7:0] wd, input logic pll);
        bit   wasActive;
        bit   wr;
        bit   dip;
        exp_t e;
        int   field;
        mN++;
        if (!rn) begin
            for (int i = 0; i < 32; i++) mRegs[i] = rstVal(i);
            mPtr = 0; mRd = 8'h00; mLock = 1'b0; mErr = 1'b0;
            mActive = 1'b0; mStart = -1000; mLockedEdges = 0;
        end else begin
            wasActive = mActive;
            wr = (opc == WR);
            if (opc == RD) mRd = mRegs[mPtr];
            if (wr) mRegs[mPtr] = wd;
            if (opc == CLR || (!pll && !wasActive)) mPtr = 0;
            else if (inc) mPtr = (mPtr + 1) % 32;
            mActive = !pll;
            if (!mActive) begin
                mLock = 1'b0;
                mLockedEdges = 0;
            end else if (!wasActive || wr) begin
                mStart = mN;
                field = int'(mRegs[17] & 8'h07);
                mOk = (field >= 3) && (field <= 7);
                mLock = 1'b0;
            end else begin
                if (mN == mStart + 1) mErr = !mOk;
                if (mOk && (mN - mStart >= LOCK_DLY + 2)) begin
                    dip = GLITCH && (mLockedEdges >= 16) && (mLockedEdges <= 19);
                    mLock = !dip;
                    mLockedEdges++;
                end else begin
                    mLock = 1'b0;
                end
            end
        end
        e.rd = mRd; e.lock = mLock; e.err = mErr; e.ptr = 5'(mPtr);
        expQ.push_back(e);
    endtask

    task automatic cycle(input logic rn, input logic inc, input logic [1:0] opc,
                         input logic [7:0] wd, input logic pll);
        @(negedge clk);
        rstN = rn; mdInc = inc; mdOpc = opc; wrData = wd; pllRst = pll;
        modelStep(rn, inc, opc, wd, pll);
    endtask

    task automatic idle(input int n, input logic pll);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, NOP, 8'h00, pll);
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        nTests++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s at %0t: actual 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Monitor: after each active edge, compare the DUT against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                check("rd_data", rdData, e.rd);
                check("lock", {7'd0, lockOut}, {7'd0, e.lock});
                check("cfg_err", {7'd0, cfgErr}, {7'd0, e.err});
                check("ptr", {3'd0, ptrOut}, {3'd0, e.ptr});
            end
        end
    end

    initial begin
        logic       rn;
        logic       inc;
        logic       rpll;
        logic [1:0] op;
        logic [7:0] wd;
        int         r;
        int         wrPct;

        // Reset state, reads of the reset table, failing check on release
        repeat (3) cycle(1'b0, 1'b0, NOP, 8'h00, 1'b1);
        cycle(1'b1, 1'b0, RD, 8'h00, 1'b1);
        repeat (17) cycle(1'b1, 1'b1, NOP, 8'h00, 1'b1);
        cycle(1'b1, 1'b0, RD, 8'h00, 1'b1);
        idle(6, 1'b0);

        // Valid config, release, exact lock latency
        cycle(1'b1, 1'b0, NOP, 8'h00, 1'b1);
        cycle(1'b1, 1'b0, CLR, 8'h00, 1'b1);
        repeat (17) cycle(1'b1, 1'b1, NOP, 8'h00, 1'b1);
        cycle(1'b1, 1'b0, WR, 8'h05, 1'b1);
        idle(LOCK_DLY + 10, 1'b0);

        // Write+INC, pointer wrap, CLR overriding INC
        repeat (17) cycle(1'b1, 1'b1, NOP, 8'h00, 1'b0);
        cycle(1'b1, 1'b1, WR, 8'h03, 1'b0);
        cycle(1'b1, 1'b0, RD, 8'h00, 1'b0);
        cycle(1'b1, 1'b1, CLR, 8'h00, 1'b0);
        repeat (31) cycle(1'b1, 1'b1, NOP, 8'h00, 1'b0);
        cycle(1'b1, 1'b1, NOP, 8'h00, 1'b0);
        repeat (17) cycle(1'b1, 1'b1, NOP, 8'h00, 1'b0);
        cycle(1'b1, 1'b0, RD, 8'h00, 1'b0);

        // Write while locked drops and re-acquires lock; out-of-range field fails
        idle(LOCK_DLY + 6, 1'b0);
        cycle(1'b1, 1'b0, WR, 8'h05, 1'b0);
        idle(LOCK_DLY + 6, 1'b0);
        cycle(1'b1, 1'b0, WR, 8'h08, 1'b0);
        idle(8, 1'b0);

        // Reset in the middle of acquisition restores the table
        cycle(1'b1, 1'b0, WR, 8'h05, 1'b0);
        idle(10, 1'b0);
        cycle(1'b0, 1'b0, NOP, 8'h00, 1'b0);
        cycle(1'b0, 1'b0, NOP, 8'h00, 1'b1);
        idle(2, 1'b1);
        cycle(1'b1, 1'b0, CLR, 8'h00, 1'b1);
        repeat (12) cycle(1'b1, 1'b1, NOP, 8'h00, 1'b1);
        cycle(1'b1, 1'b0, RD, 8'h00, 1'b1);

        // Long steady lock (glitch window when enabled)
        cycle(1'b1, 1'b0, CLR, 8'h00, 1'b1);
        repeat (17) cycle(1'b1, 1'b1, NOP, 8'h00, 1'b1);
        cycle(1'b1, 1'b0, WR, 8'h06, 1'b1);
        idle(1100, 1'b0);

        // Randomized traffic: alternate write-heavy and write-free segments so locks can complete
        rpll = 1'b0;
        for (int seg = 0; seg < 20; seg++) begin
            wrPct = (seg % 2 == 0) ? 15 : 0;
            for (int k = 0; k < 100; k++) begin
                r = int'($urandom_range(99));
                if (r < wrPct) op = WR;
                else if (r < wrPct + 40) op = RD;
                else if (r < wrPct + 44) op = CLR;
                else op = NOP;
                rn  = ($urandom_range(299) != 0);
                inc = 1'($urandom_range(1));
                wd  = 8'($urandom);
                if ($urandom_range(79) == 0) rpll = ~rpll;
                cycle(rn, inc, op, wd, rpll);
            end
        end

        @(posedge clk);
        #2;
        if (expQ.size() != 0) begin
            nTests++;
            nFails++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", nTests, nFails);
        $finish;
    end

endmodule
